// File: rtl/mips_pc_register_if.sv
// Interface for the PC register stage: resolved-action inputs from the resolver
// and fetch-side PC outputs.
interface mips_pc_register_if;
  logic        actionValid;
  logic [1:0]  action;
  logic [31:0] basePc;
  logic [15:0] imm;
  logic [25:0] jumpIndex;
  logic [31:0] regValue;
  logic        stall;
  logic [31:0] pc;
  logic        pcValid;
  logic        redirect;
  logic        fault;
  logic [31:0] faultAddr;

  modport master (
    output actionValid, action, basePc, imm, jumpIndex, regValue, stall,
    input  pc, pcValid, redirect, fault, faultAddr
  );

  modport slave (
    input  actionValid, action, basePc, imm, jumpIndex, regValue, stall,
    output pc, pcValid, redirect, fault, faultAddr
  );
endinterface

// File: rtl/mips_pc_register.sv
// Architectural fetch PC with redirect pulse generation, stall-time buffering of
// a pending redirect, and vectoring to FAULT_PC on a misaligned register jump.
module mips_pc_register #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] FAULT_PC = 32'h8000_0180
) (
  input logic               clock,
  input logic               resetN,
  mips_pc_register_if.slave bus
);

  typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

  localparam logic [1:0] ACT_INC    = 2'd0;
  localparam logic [1:0] ACT_BRANCH = 2'd1;
  localparam logic [1:0] ACT_JUMP   = 2'd2;
  localparam logic [1:0] ACT_JREG   = 2'd3;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_pcValid;
  logic        r_redirect;
  logic        r_fault;
  logic [31:0] r_faultAddr;
  logic [31:0] r_pendingPc;
  logic        r_pendingFault;
  logic [31:0] r_pendingFaultAddr;

  logic        w_redirectReq;
  logic        w_misaligned;
  logic [31:0] w_seqPc;
  logic [31:0] w_branchOffset;
  logic [31:0] w_target;

  assign w_redirectReq  = bus.actionValid && (bus.action != ACT_INC);
  assign w_misaligned   = bus.actionValid && (bus.action == ACT_JREG) &&
                          (bus.regValue[1:0] != 2'b00);
  assign w_seqPc        = r_pc + 32'd4;
  assign w_branchOffset = {{14{bus.imm[15]}}, bus.imm, 2'b00};

  // A misaligned register jump redirects to the fault vector instead of regValue.
  always_comb begin
    w_target = w_seqPc;
    case (bus.action)
      ACT_BRANCH: w_target = bus.basePc + w_branchOffset;
      ACT_JUMP:   w_target = {bus.basePc[31:28], bus.jumpIndex, 2'b00};
      ACT_JREG:   w_target = w_misaligned ? FAULT_PC : bus.regValue;
      default:    w_target = w_seqPc;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      r_state            <= BOOT;
      r_pc               <= RESET_PC;
      r_pcValid          <= 1'b0;
      r_redirect         <= 1'b0;
      r_fault            <= 1'b0;
      r_faultAddr        <= 32'd0;
      r_pendingPc        <= 32'd0;
      r_pendingFault     <= 1'b0;
      r_pendingFaultAddr <= 32'd0;
    end else begin
      r_redirect <= 1'b0;
      r_fault    <= 1'b0;
      case (r_state)
        BOOT: begin
          r_state   <= RUN;
          r_pcValid <= 1'b1;
        end
        RUN: begin
          if (w_redirectReq) begin
            if (!bus.stall) begin
              r_pc       <= w_target;
              r_redirect <= 1'b1;
              r_fault    <= w_misaligned;
              if (w_misaligned) r_faultAddr <= bus.regValue;
            end else begin
              r_pendingPc        <= w_target;
              r_pendingFault     <= w_misaligned;
              r_pendingFaultAddr <= bus.regValue;
              r_state            <= PEND;
            end
          end else if (!bus.stall) begin
            r_pc <= w_seqPc;
          end
        end
        PEND: begin
          // Newest request wins, both while stalled and on the release cycle.
          if (bus.stall) begin
            if (w_redirectReq) begin
              r_pendingPc        <= w_target;
              r_pendingFault     <= w_misaligned;
              r_pendingFaultAddr <= bus.regValue;
            end
          end else begin
            r_redirect <= 1'b1;
            r_state    <= RUN;
            if (w_redirectReq) begin
              r_pc    <= w_target;
              r_fault <= w_misaligned;
              if (w_misaligned) r_faultAddr <= bus.regValue;
            end else begin
              r_pc    <= r_pendingPc;
              r_fault <= r_pendingFault;
              if (r_pendingFault) r_faultAddr <= r_pendingFaultAddr;
            end
            r_pendingFault <= 1'b0;
          end
        end
        default: r_state <= BOOT;
      endcase
    end
  end

  assign bus.pc        = r_pc;
  assign bus.pcValid   = r_pcValid;
  assign bus.redirect  = r_redirect;
  assign bus.fault     = r_fault;
  assign bus.faultAddr = r_faultAddr;

endmodule

// File: tb/tb_mips_pc_register.sv
// Directed-vector bench for mips_pc_register: each task drives one scenario and
// compares pc/pcValid/redirect/fault/faultAddr against hand-computed values.
module tb_mips_pc_register;
  logic clock;
  logic resetN;
  int   errors;
  int   checks;

  mips_pc_register_if bus();

  mips_pc_register dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs are driven 1 time unit after a rising edge; outputs sampled at the same point.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] a, input logic [31:0] base,
                       input logic [15:0] im, input logic [25:0] ji,
                       input logic [31:0] rv, input logic st);
    bus.actionValid = v;
    bus.action      = a;
    bus.basePc      = base;
    bus.imm         = im;
    bus.jumpIndex   = ji;
    bus.regValue    = rv;
    bus.stall       = st;
  endtask

  task automatic idle(input logic st);
    drive(1'b0, 2'd0, 32'd0, 16'd0, 26'd0, 32'd0, st);
  endtask

  task automatic expect_state(input string name, input logic [31:0] ePc,
                              input logic eValid, input logic eRed, input logic eFault);
    checks++;
    if (bus.pc !== ePc) begin
      errors++;
      $display("[TB] FAIL %s pc: got %h expected %h", name, bus.pc, ePc);
    end
    checks++;
    if (bus.pcValid !== eValid) begin
      errors++;
      $display("[TB] FAIL %s pcValid: got %b expected %b", name, bus.pcValid, eValid);
    end
    checks++;
    if (bus.redirect !== eRed) begin
      errors++;
      $display("[TB] FAIL %s redirect: got %b expected %b", name, bus.redirect, eRed);
    end
    checks++;
    if (bus.fault !== eFault) begin
      errors++;
      $display("[TB] FAIL %s fault: got %b expected %b", name, bus.fault, eFault);
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    idle(1'b0);
    tick();
    tick();
    expect_state("reset", 32'h0040_0000, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.faultAddr !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset faultAddr: got %h expected %h", bus.faultAddr, 32'd0);
    end
  endtask

  task automatic test_sequential();
    resetN = 1'b1;
    tick();
    expect_state("boot_to_run", 32'h0040_0000, 1'b1, 1'b0, 1'b0);
    tick();
    expect_state("seq1", 32'h0040_0004, 1'b1, 1'b0, 1'b0);
    tick();
    expect_state("seq2", 32'h0040_0008, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    expect_state("seq4", 32'h0040_0010, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_branch();
    drive(1'b1, 2'd1, 32'h0040_0014, 16'hFFFC, 26'd0, 32'd0, 1'b0);
    tick();
    expect_state("branch_taken", 32'h0040_0004, 1'b1, 1'b1, 1'b0);
    idle(1'b0);
    tick();
    expect_state("branch_after", 32'h0040_0008, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_jump_stalled();
    drive(1'b1, 2'd2, 32'h9000_0000, 16'd0, 26'h0000100, 32'd0, 1'b1);
    tick();
    expect_state("jump_pend1", 32'h0040_0008, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    tick();
    expect_state("jump_pend2", 32'h0040_0008, 1'b1, 1'b0, 1'b0);
    tick();
    expect_state("jump_pend3", 32'h0040_0008, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    tick();
    expect_state("jump_release", 32'h9000_0400, 1'b1, 1'b1, 1'b0);
    tick();
    expect_state("jump_after", 32'h9000_0404, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_pend_overwrite();
    drive(1'b1, 2'd3, 32'd0, 16'd0, 26'd0, 32'h0040_0100, 1'b1);
    tick();
    expect_state("ovr_pend", 32'h9000_0404, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 2'd3, 32'd0, 16'd0, 26'd0, 32'h0040_0200, 1'b1);
    tick();
    expect_state("ovr_newest", 32'h9000_0404, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    tick();
    expect_state("ovr_release", 32'h0040_0200, 1'b1, 1'b1, 1'b0);
    tick();
    expect_state("ovr_single_pulse", 32'h0040_0204, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_misaligned();
    drive(1'b1, 2'd3, 32'd0, 16'd0, 26'd0, 32'h0040_0203, 1'b0);
    tick();
    expect_state("misalign_taken", 32'h8000_0180, 1'b1, 1'b1, 1'b1);
    checks++;
    if (bus.faultAddr !== 32'h0040_0203) begin
      errors++;
      $display("[TB] FAIL misalign faultAddr: got %h expected %h", bus.faultAddr, 32'h0040_0203);
    end
    idle(1'b0);
    tick();
    expect_state("misalign_after", 32'h8000_0184, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_pending_fault();
    drive(1'b1, 2'd3, 32'd0, 16'd0, 26'd0, 32'h0000_0011, 1'b1);
    tick();
    expect_state("pfault_pend", 32'h8000_0184, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    tick();
    expect_state("pfault_hold", 32'h8000_0184, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    tick();
    expect_state("pfault_release", 32'h8000_0180, 1'b1, 1'b1, 1'b1);
    checks++;
    if (bus.faultAddr !== 32'h0000_0011) begin
      errors++;
      $display("[TB] FAIL pfault faultAddr: got %h expected %h", bus.faultAddr, 32'h0000_0011);
    end
    drive(1'b1, 2'd3, 32'd0, 16'd0, 26'd0, 32'h0000_0022, 1'b1);
    tick();
    expect_state("pfault_pend2", 32'h8000_0180, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 32'h0000_1000, 16'h0004, 26'd0, 32'd0, 1'b1);
    tick();
    idle(1'b0);
    tick();
    expect_state("pfault_cleared", 32'h0000_1010, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.faultAddr !== 32'h0000_0011) begin
      errors++;
      $display("[TB] FAIL pfault_cleared faultAddr: got %h expected %h", bus.faultAddr, 32'h0000_0011);
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, 2'd3, 32'd0, 16'd0, 26'd0, 32'hFFFF_FFFC, 1'b0);
    tick();
    expect_state("wrap_load", 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 2'd0, 32'd0, 16'd0, 26'd0, 32'd0, 1'b1);
    tick();
    expect_state("inc_stall_hold", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 2'd0, 32'd0, 16'd0, 26'd0, 32'd0, 1'b0);
    tick();
    expect_state("wrap_zero", 32'h0000_0000, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_in_pend();
    drive(1'b1, 2'd3, 32'd0, 16'd0, 26'd0, 32'h0040_0300, 1'b1);
    tick();
    expect_state("rst_pend", 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    resetN = 1'b0;
    drive(1'b1, 2'd1, 32'h0000_2000, 16'h0001, 26'd0, 32'd0, 1'b0);
    tick();
    expect_state("rst_wins", 32'h0040_0000, 1'b0, 1'b0, 1'b0);
    resetN = 1'b1;
    idle(1'b0);
    tick();
    expect_state("rst_boot", 32'h0040_0000, 1'b1, 1'b0, 1'b0);
    tick();
    expect_state("rst_discarded", 32'h0040_0004, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    resetN = 1'b0;
    idle(1'b0);
    test_reset();
    test_sequential();
    test_branch();
    test_jump_stalled();
    test_pend_overwrite();
    test_misaligned();
    test_pending_fault();
    test_wrap();
    test_reset_in_pend();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
